// File: rtl/uart_bus_master.sv
// Serial-line bus initiator: 8N1 command frames from a host PC become 32-bit
// reads/writes on the PicoSoC native memory bus, with serial responses.
module uart_bus_master #(
  parameter int CLK_DIV       = 104,
  parameter int FRAME_TIMEOUT = 1000000,
  parameter int BUS_TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ser_rx,
  output logic        ser_tx,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST  = 16'(CLK_DIV / 2 - 1);
  localparam logic [31:0] FRAME_LAST = 32'(FRAME_TIMEOUT - 1);
  localparam logic [31:0] BUS_LAST   = 32'(BUS_TIMEOUT - 1);
  localparam logic [7:0]  CMD_WRITE  = 8'h57;
  localparam logic [7:0]  CMD_READ   = 8'h52;
  localparam logic [7:0]  RSP_ACK    = 8'h4B;
  localparam logic [7:0]  RSP_ERR    = 8'h3F;
  localparam logic [7:0]  RSP_TMO    = 8'h45;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  rx_state_t   rx_state_reg;
  logic        rx_meta_reg, rx_sync_reg, rx_wait_high_reg;
  logic [15:0] rx_cnt_reg;
  logic [2:0]  rx_bit_reg;
  logic [7:0]  rx_shift_reg;
  logic        rx_byte_valid, rx_frame_err;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_state_reg     <= RX_IDLE;
      rx_meta_reg      <= 1'b1;
      rx_sync_reg      <= 1'b1;
      rx_wait_high_reg <= 1'b0;
      rx_cnt_reg       <= '0;
      rx_bit_reg       <= '0;
      rx_shift_reg     <= '0;
      rx_byte_valid    <= 1'b0;
      rx_frame_err     <= 1'b0;
    end else begin
      rx_meta_reg   <= ser_rx;
      rx_sync_reg   <= rx_meta_reg;
      rx_byte_valid <= 1'b0;
      rx_frame_err  <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          // After a byte the line must return high before a new start bit counts
          if (rx_wait_high_reg) begin
            if (rx_sync_reg) rx_wait_high_reg <= 1'b0;
          end else if (!rx_sync_reg) begin
            rx_state_reg <= RX_START;
            rx_cnt_reg   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_reg == HALF_LAST) begin
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg == DIV_LAST) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
            rx_bit_reg   <= rx_bit_reg + 3'd1;
            if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_reg == DIV_LAST) begin
            rx_cnt_reg       <= '0;
            rx_byte_valid    <= rx_sync_reg;
            rx_frame_err     <= !rx_sync_reg;
            rx_wait_high_reg <= 1'b1;
            rx_state_reg     <= RX_IDLE;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 16'd1;
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  state_t      state_reg;
  logic        is_write_reg;
  logic [1:0]  byte_idx_reg;
  logic [31:0] timer_reg;
  logic [31:0] resp_buf_reg;
  logic [2:0]  resp_left_reg;
  logic        tx_active_reg;
  logic [8:0]  tx_shift_reg;
  logic [3:0]  tx_bit_reg;
  logic [15:0] tx_cnt_reg;
  logic        ser_tx_reg, mem_valid_reg, busy_reg;
  logic [31:0] mem_addr_reg, mem_wdata_reg;
  logic [3:0]  mem_wstrb_reg;
  logic        tx_bit_end, tx_stop_end, tx_load;

  assign tx_bit_end  = tx_active_reg && (tx_cnt_reg == DIV_LAST);
  assign tx_stop_end = tx_bit_end && (tx_bit_reg == 4'd9);
  // Next byte loads on the same edge the previous stop bit ends: no idle gap
  assign tx_load = (state_reg == S_RESP) && (resp_left_reg != 3'd0) &&
                   (!tx_active_reg || tx_stop_end);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= S_IDLE;
      is_write_reg  <= 1'b0;
      byte_idx_reg  <= '0;
      timer_reg     <= '0;
      resp_buf_reg  <= '0;
      resp_left_reg <= '0;
      tx_active_reg <= 1'b0;
      tx_shift_reg  <= '1;
      tx_bit_reg    <= '0;
      tx_cnt_reg    <= '0;
      ser_tx_reg    <= 1'b1;
      mem_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wstrb_reg <= '0;
    end else begin
      if (tx_load) begin
        ser_tx_reg    <= 1'b0;
        tx_shift_reg  <= {1'b1, resp_buf_reg[7:0]};
        resp_buf_reg  <= {8'h00, resp_buf_reg[31:8]};
        resp_left_reg <= resp_left_reg - 3'd1;
        tx_bit_reg    <= '0;
        tx_cnt_reg    <= '0;
        tx_active_reg <= 1'b1;
      end else if (tx_bit_end) begin
        tx_cnt_reg <= '0;
        if (tx_bit_reg == 4'd9) begin
          tx_active_reg <= 1'b0;
        end else begin
          ser_tx_reg   <= tx_shift_reg[0];
          tx_shift_reg <= {1'b1, tx_shift_reg[8:1]};
          tx_bit_reg   <= tx_bit_reg + 4'd1;
        end
      end else if (tx_active_reg) begin
        tx_cnt_reg <= tx_cnt_reg + 16'd1;
      end

      if (rx_frame_err && state_reg != S_RESP) begin
        mem_valid_reg <= 1'b0;
        mem_wstrb_reg <= 4'h0;
        busy_reg      <= 1'b1;
        resp_buf_reg  <= {24'd0, RSP_ERR};
        resp_left_reg <= 3'd1;
        state_reg     <= S_RESP;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (rx_byte_valid) begin
              busy_reg <= 1'b1;
              if (rx_shift_reg == CMD_WRITE || rx_shift_reg == CMD_READ) begin
                is_write_reg <= (rx_shift_reg == CMD_WRITE);
                byte_idx_reg <= '0;
                timer_reg    <= '0;
                state_reg    <= S_ADDR;
              end else begin
                resp_buf_reg  <= {24'd0, RSP_ERR};
                resp_left_reg <= 3'd1;
                state_reg     <= S_RESP;
              end
            end
          end
          S_ADDR, S_DATA: begin
            if (rx_byte_valid) begin
              if (state_reg == S_ADDR) mem_addr_reg[{byte_idx_reg, 3'b000} +: 8] <= rx_shift_reg;
              else                     mem_wdata_reg[{byte_idx_reg, 3'b000} +: 8] <= rx_shift_reg;
              byte_idx_reg <= byte_idx_reg + 2'd1;
              timer_reg    <= '0;
              if (byte_idx_reg == 2'd3)
                state_reg <= (state_reg == S_ADDR && is_write_reg) ? S_DATA : S_BUS;
            end else if (timer_reg == FRAME_LAST) begin
              timer_reg <= '0;
              busy_reg  <= 1'b0;
              state_reg <= S_IDLE;
            end else begin
              timer_reg <= timer_reg + 32'd1;
            end
          end
          S_BUS: begin
            if (!mem_valid_reg) begin
              mem_valid_reg <= 1'b1;
              mem_wstrb_reg <= is_write_reg ? 4'hF : 4'h0;
              timer_reg     <= '0;
            end else if (mem_ready) begin
              mem_valid_reg <= 1'b0;
              mem_wstrb_reg <= 4'h0;
              resp_buf_reg  <= is_write_reg ? {24'd0, RSP_ACK} : mem_rdata;
              resp_left_reg <= is_write_reg ? 3'd1 : 3'd4;
              state_reg     <= S_RESP;
            end else if (timer_reg == BUS_LAST) begin
              mem_valid_reg <= 1'b0;
              mem_wstrb_reg <= 4'h0;
              resp_buf_reg  <= {24'd0, RSP_TMO};
              resp_left_reg <= 3'd1;
              state_reg     <= S_RESP;
            end else begin
              timer_reg <= timer_reg + 32'd1;
            end
          end
          S_RESP: begin
            if (tx_stop_end && resp_left_reg == 3'd0) begin
              busy_reg  <= 1'b0;
              state_reg <= S_IDLE;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  assign ser_tx    = ser_tx_reg;
  assign mem_valid = mem_valid_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wstrb = mem_wstrb_reg;
  assign busy      = busy_reg;
endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- UART-driven bus initiator for host debug access: a PC sends command frames over a serial line, and the block performs 32-bit reads/writes on the PicoSoC native memory bus.
- It is the counterpart of the SoC's memory-mapped UART peripheral: that block is a bus responder fed by the CPU; this block is a bus master fed by the serial line.
- Sits beside the CPU on the bus arbiter's second master port.
- Contains its own 8N1 receiver and transmitter, a command-frame FSM and a bus handshake engine.

Parameters:
CLK_DIV, 104, clock cycles per UART bit (legal range 4..65535).
FRAME_TIMEOUT, 1000000, max cycles between received bytes inside a frame before the frame is aborted.
BUS_TIMEOUT, 4096, max cycles mem_valid waits for mem_ready before the transaction is aborted.

Ports:
clk  input  1  clock.
resetn  input  1  reset, synchronous, active-low.
ser_rx  input  1  UART receive line, asynchronous, idle high.
ser_tx  output  1  UART transmit line, idle high.
mem_valid  output  1  bus request.
mem_ready  input  1  bus completion strobe from slave.
mem_addr  output  32  bus byte address.
mem_wdata  output  32  write data.
mem_wstrb  output  4  byte enables; 4'hF for write, 4'h0 for read.
mem_rdata  input  32  read data, valid when mem_ready=1.
busy  output  1  high from first command byte accepted until last response bit sent.

Behaviour:
- Reset: ser_tx=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0; FSM=IDLE; rx/tx idle; all counters 0. Reset mid-frame or mid-transaction aborts immediately; mem_valid drops on the reset cycle.

Receiver:
- ser_rx passes through a 2-FF synchronizer.
- In RX_IDLE, a synchronized 0 starts a byte.
- Start bit is re-sampled at CLK_DIV/2 (integer division) cycles; if it reads 1, it is a glitch and the receiver returns to RX_IDLE.
- 8 data bits are sampled LSB first, each CLK_DIV cycles after the previous sample.
- The stop bit is sampled CLK_DIV cycles after the last data bit.
  - Stop=1: rx_byte_valid pulses for 1 cycle.
  - Stop=0: framing error pulse.
- The receiver then waits in RX_IDLE for the line to go high before accepting a new start bit.

Transmitter:
- Shift register {1, byte, 0} sent LSB first, each bit held exactly CLK_DIV cycles, 10*CLK_DIV cycles per byte.
- The next queued byte starts on the cycle after the previous stop bit ends (no extra idle gap).

Frame protocol (multi-byte fields little-endian):
- Write: 0x57, A0..A3, D0..D3. Response: 0x4B.
- Read: 0x52, A0..A3. Response: R0..R3 (mem_rdata LSB first).
- Any other command byte: response 0x3F; FSM returns to IDLE.
- Bus timeout: response 0x45.
- Framing error in any state except RESP: frame discarded, response 0x3F.

Frame FSM states:
- IDLE: wait for command byte.
  - 0x57 or 0x52: latch the command; busy=1; ADDR, byte count 0.
  - Other: RESP with 0x3F.
- ADDR: collect 4 bytes into mem_addr[8k+7:8k].
  - After byte 3: Write goes to DATA; Read goes to BUS.
- DATA: collect 4 bytes into mem_wdata; after byte 3 go to BUS.
- BUS: assert mem_valid from the cycle after entry. mem_wstrb is 4'hF for write, 4'h0 for read.
  - mem_addr, mem_wdata and mem_wstrb are stable while mem_valid=1.
  - On the cycle with mem_valid&&mem_ready: read data is captured from mem_rdata; mem_valid=0 on the next cycle; go to RESP.
  - mem_ready arriving in the same cycle mem_valid rises is a legal 1-cycle transaction.
  - mem_ready while mem_valid=0 is ignored.
  - If BUS_TIMEOUT cycles elapse with mem_valid=1 and no mem_ready: drop mem_valid; RESP with 0x45.
- RESP: transmit 1 or 4 bytes.
  - Received bytes are discarded in this state.
  - After the final stop bit: busy=0, go to IDLE.

Frame timeout:
- The inter-byte counter runs in ADDR/DATA and resets on each rx_byte_valid.
- Reaching FRAME_TIMEOUT returns the FSM to IDLE silently; busy=0, no response.

Test Plan:
- CLK_DIV=16; send 57 10 00 00 20 EF BE AD DE, slave ready 3 cycles after valid -> one transaction with addr=0x20000010, wdata=0xDEADBEEF, wstrb=F, valid held 4 cycles; ser_tx sends 0x4B.
- Send 52 04 00 00 00, slave returns 0x12345678 with ready in the same cycle valid rises -> valid high 1 cycle, wstrb=0; ser_tx bytes 78 56 34 12, with 10*16 cycles per byte and no gaps.
- Send 0x41 -> no bus activity; ser_tx sends 0x3F; busy returns to 0.
- Read to an address whose slave never asserts ready, BUS_TIMEOUT=64 -> mem_valid high exactly 64 cycles then low; ser_tx sends 0x45.
- Send 57 10 00 then idle longer than FRAME_TIMEOUT=500 -> FSM back in IDLE with no ser_tx activity; a following read frame completes correctly.
- Stop bit forced to 0 on the 2nd address byte -> response 0x3F, no mem_valid. Separately, assert resetn=0 during BUS -> mem_valid=0 and ser_tx=1 on the reset cycle.
